pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/cvp14_pkg.sv | 21 ++
 rtl/pc_sequencer.sv | 110 +++++++++++
 2 files changed

// File: rtl/cvp14_pkg.sv
// Shared constants and state type for the PC sequencer.
package cvp14_pkg;

    // Default PC address width.
    localparam int ADDR_W = 16;

    // Default first fetch address after reset.
    localparam logic [ADDR_W-1:0] RESET_VEC = 16'h0000;

    // Flush counter width: holds up to 7 post-redirect cycles.
    localparam int FLUSH_CNT_W = 3;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_RUN    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_HALTED = 3'd4
    } pc_seq_state_t;

endpackage

// File: rtl/pc_sequencer.sv
// PC sequencer: chooses the next fetch address (sequential, hold, branch or
// jump), drives the fetch request, and times the pipeline flush after a
// redirect. The incrementer, priority mux and flush counter are all inline.
module pc_sequencer #(
    parameter int                      ADDR_W       = cvp14_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0]       RESET_VEC    = cvp14_pkg::RESET_VEC,
    parameter int                      FLUSH_CYCLES = 2
) (
    input  logic              Clk1,
    input  logic              rst,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic              stall,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              halt,
    input  logic              resume,
    input  logic              fetch_ack,
    output logic [ADDR_W-1:0] nextAddr,
    output logic              fetch_req,
    output logic              flush,
    output logic              halted
);
    import cvp14_pkg::*;

    // The redirect cycle itself is the first flush cycle, so the counter
    // only has to cover the remaining FLUSH_CYCLES-1 cycles.
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    pc_seq_state_t           state_q, state_d;
    logic [FLUSH_CNT_W-1:0]  cnt_q, cnt_d;

    logic                    redirect;
    logic [ADDR_W-1:0]       redirect_tgt;
    logic [ADDR_W-1:0]       addr_inc;
    logic                    cnt_nz;
    logic                    active;

    // A jump beats a simultaneous branch; the branch is simply dropped.
    assign redirect     = jmp_valid | br_valid;
    assign redirect_tgt = jmp_valid ? jmp_target : br_target;
    // Plain modulo increment: the top address wraps to zero with no flag.
    assign addr_inc     = iAddr + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign cnt_nz       = (cnt_q != '0);
    // States in which redirects, halt, stall and fetch_ack are honoured.
    assign active       = (state_q == ST_RUN) || (state_q == ST_WAIT) ||
                          (state_q == ST_FLUSH);

    // State and flush counter registers; reset overrides everything.
    always_ff @(posedge Clk1) begin
        if (rst) begin
            state_q <= ST_BOOT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and counter. The counter runs down in every state
    // (including HALTED) and is only reloaded by an honoured redirect.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_nz ? (cnt_q - 1'b1) : '0;
        if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
        end else if (state_q == ST_HALTED) begin
            if (resume) state_d = ST_RUN;
        end else if (active) begin
            if (redirect) begin
                cnt_d   = FLUSH_LOAD;
                state_d = halt ? ST_HALTED : ST_FLUSH;
            end else if (halt) begin
                state_d = ST_HALTED;
            end else if (stall) begin
                state_d = state_q;
            end else if ((state_q == ST_FLUSH) && cnt_nz) begin
                state_d = ST_FLUSH;
            end else begin
                state_d = fetch_ack ? ST_RUN : ST_WAIT;
            end
        end
    end

    // Outputs: priority mux for nextAddr, plus request/flush/halted flags.
    always_comb begin
        nextAddr  = iAddr;
        fetch_req = 1'b0;
        flush     = cnt_nz;
        halted    = 1'b0;
        if (state_q == ST_BOOT) begin
            nextAddr = RESET_VEC;
            flush    = 1'b0;
        end else if (state_q == ST_HALTED) begin
            halted   = 1'b1;
        end else if (active) begin
            fetch_req = 1'b1;
            if (redirect) begin
                nextAddr = redirect_tgt;
                flush    = 1'b1;
            end else if (halt || stall) begin
                nextAddr = iAddr;
            end else if (fetch_ack) begin
                nextAddr = addr_inc;
            end
        end
    end

endmodule
